// File: rtl/eight_bit_select_subtractor.sv
// Two-stage carry-select subtractor with valid/ready handshake.
// S1 splits the operands into halves and precomputes both upper-half outcomes; S2 picks one using the low-half borrow.
module eight_bit_select_subtractor #(
  parameter int WIDTH = 8  // must be even and >= 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] output_diff,
  output logic             output_Bout
);
  localparam int HALF = WIDTH / 2;

  logic            en;
  logic [2:1]      vld_pipe;   // [1] = S1 valid, [2] = S2 valid
  logic [HALF:0]   lo_c, hi0_c, hi1_c;
  logic [HALF-1:0] s1_diff_lo;
  logic            s1_b_mid;
  logic [HALF:0]   s1_hi0, s1_hi1;

  // The whole pipe advances together; only a valid, unaccepted result stalls it.
  assign en        = !vld_pipe[2] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[2];

  // Each half result is {borrow, diff}: the MSB is set when the subtraction goes negative.
  assign lo_c  = {1'b0, A[HALF-1:0]} - {1'b0, B[HALF-1:0]} - {{HALF{1'b0}}, Bin};
  assign hi0_c = {1'b0, A[WIDTH-1:HALF]} - {1'b0, B[WIDTH-1:HALF]};
  assign hi1_c = {1'b0, A[WIDTH-1:HALF]} - {1'b0, B[WIDTH-1:HALF]} - {{HALF{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe    <= '0;
      s1_diff_lo  <= '0;
      s1_b_mid    <= 1'b0;
      s1_hi0      <= '0;
      s1_hi1      <= '0;
      output_diff <= '0;
      output_Bout <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      s1_diff_lo  <= lo_c[HALF-1:0];
      s1_b_mid    <= lo_c[HALF];
      s1_hi0      <= hi0_c;
      s1_hi1      <= hi1_c;
      vld_pipe[2] <= vld_pipe[1];
      // Carry-select: only a half-width mux sits between S1 and S2.
      output_diff <= {(s1_b_mid ? s1_hi1[HALF-1:0] : s1_hi0[HALF-1:0]), s1_diff_lo};
      output_Bout <= s1_b_mid ? s1_hi1[HALF] : s1_hi0[HALF];
    end
  end

endmodule
